// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// data_memory_arbiter : round-robin share of a single-port data memory
// between the CPU port (0) and a loader/debug port (1); optional macro
// ARB_PERF_COUNTERS_EN adds grant/conflict counters.   Rev 1.0
// ============================================================================
module data_memory_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_addr1,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    output logic [1:0]  req_ready,
    output logic [1:0]  resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_write_enable,
    input  logic [31:0] mem_data_out,
`ifdef ARB_PERF_COUNTERS_EN
    output logic [31:0] grant_count0,
    output logic [31:0] grant_count1,
    output logic [31:0] conflict_count,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t      state;
    state_t      next_state;
    logic        last_grant;
    logic        owner;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  counter;
    logic        grant;
    logic        accept;
    logic        misaligned;

    // Both requesting: hand the grant to whoever did not win last time.
    always_comb begin
        grant = req_valid[1];
        if (req_valid == 2'b11) begin
            grant = ~last_grant;
        end
    end

    assign req_ready  = (state == ST_IDLE && reset && (|req_valid)) ?
                        (grant ? 2'b10 : 2'b01) : 2'b00;
    assign accept     = |(req_valid & req_ready);
    assign misaligned = |addr[1:0];
    assign busy       = (state != ST_IDLE);

    assign mem_address      = busy ? addr  : 32'd0;
    assign mem_data_in      = busy ? wdata : 32'd0;
    assign mem_write_enable = (state == ST_ACCESS) && write && !misaligned;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (counter == 4'd1) begin
                    next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            write      <= 1'b0;
            addr       <= 32'd0;
            wdata      <= 32'd0;
            counter    <= 4'd0;
        end else begin
            if (accept) begin
                last_grant <= grant;
                owner      <= grant;
                write      <= req_write[grant];
                addr       <= grant ? req_addr1  : req_addr0;
                wdata      <= grant ? req_wdata1 : req_wdata0;
                counter    <= WAIT_LOAD;
            end else if (state == ST_WAIT) begin
                counter <= counter - 4'd1;
            end
        end
    end

    // Response registers: data/err hold until the next completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= 2'b00;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else if (state == ST_ACCESS) begin
            resp_valid <= owner ? 2'b10 : 2'b01;
            resp_err   <= misaligned;
            resp_rdata <= (!write && !misaligned) ? mem_data_out : 32'd0;
        end else begin
            resp_valid <= 2'b00;
        end
    end

`ifdef ARB_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_count0   <= 32'd0;
            grant_count1   <= 32'd0;
            conflict_count <= 32'd0;
        end else if (accept) begin
            if (grant) begin
                grant_count1 <= grant_count1 + 32'd1;
            end else begin
                grant_count0 <= grant_count0 + 32'd1;
            end
            if (req_valid == 2'b11) begin
                conflict_count <= conflict_count + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// tb_data_memory_arbiter : scoreboard bench for data_memory_arbiter.  Rev 1.0
// ============================================================================
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [31:0] req_addr0;
    logic [31:0] req_addr1;
    logic [31:0] req_wdata0;
    logic [31:0] req_wdata1;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_write_enable;
    logic [31:0] mem_data_out;
    logic        busy;

    logic [1:0]  req_valid_z;
    logic [1:0]  req_ready_z;
    logic [1:0]  resp_valid_z;
    logic        resp_err_z;
    logic [31:0] resp_rdata_z;
    logic [31:0] mem_address_z;
    logic [31:0] mem_data_in_z;
    logic        mem_write_enable_z;
    logic        busy_z;
    logic [31:0] req_addr_z;

`ifdef ARB_PERF_COUNTERS_EN
    logic [31:0] gc0;
    logic [31:0] gc1;
    logic [31:0] cc;
    logic [31:0] gc0_z;
    logic [31:0] gc1_z;
    logic [31:0] cc_z;
`endif

    always #5 clk = ~clk;

    data_memory_arbiter #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out),
`ifdef ARB_PERF_COUNTERS_EN
        .grant_count0(gc0), .grant_count1(gc1), .conflict_count(cc),
`endif
        .busy(busy)
    );

    data_memory_arbiter #(.WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_z), .req_write(2'b00),
        .req_addr0(req_addr_z), .req_addr1(32'd0),
        .req_wdata0(32'd0), .req_wdata1(32'd0),
        .req_ready(req_ready_z), .resp_valid(resp_valid_z),
        .resp_err(resp_err_z), .resp_rdata(resp_rdata_z),
        .mem_address(mem_address_z), .mem_data_in(mem_data_in_z),
        .mem_write_enable(mem_write_enable_z), .mem_data_out(32'h1234_5678),
`ifdef ARB_PERF_COUNTERS_EN
        .grant_count0(gc0_z), .grant_count1(gc1_z), .conflict_count(cc_z),
`endif
        .busy(busy_z)
    );

    // Word-addressed backing store; drops address bits [1:0].
    logic [31:0] mem [0:15];
    assign mem_data_out = mem[mem_address[5:2]];
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address[5:2]] <= mem_data_in;
    end

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    resp_t resp_q[$];
    wr_t   wr_q[$];
    resp_t re;
    wr_t   we;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every response pulse and every memory write.
    always @(negedge clk) begin
        if (resp_valid != 2'b00) begin
            if (resp_q.size() == 0) begin
                check("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                re = resp_q.pop_front();
                check("resp_valid", 32'(resp_valid), (re.port == 1) ? 32'd2 : 32'd1);
                check("resp_err", 32'(resp_err), 32'(re.err));
                check("resp_rdata", resp_rdata, re.rdata);
                check("resp_cycle", 32'(cyc), 32'(re.cyc));
            end
        end
        if (mem_write_enable) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", mem_address, 32'hFFFF_FFFF);
            end else begin
                we = wr_q.pop_front();
                check("wr_addr", mem_address, we.addr);
                check("wr_data", mem_data_in, we.data);
                check("wr_cycle", 32'(cyc), 32'(we.cyc));
            end
        end
    end

    task automatic drive(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        req_valid[p] = 1'b1;
        req_write[p] = w;
        if (p == 0) begin
            req_addr0 = a; req_wdata0 = d;
        end else begin
            req_addr1 = a; req_wdata1 = d;
        end
    endtask

    task automatic single(input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd,
                          input logic exp_err, input logic exp_wr);
        bit got;
        @(posedge clk); #1;
        drive(p, w, a, d);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) got = 1'b1;
        end
        check("accept_seen", 32'(got), 32'd1);
        if (got) begin
            check("req_ready", 32'(req_ready), (p == 1) ? 32'd2 : 32'd1);
            resp_q.push_back('{p, exp_err, exp_rd, cyc + 3});
            if (exp_wr) wr_q.push_back('{a, d, cyc + 2});
        end
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (resp_q.size() != 0 || wr_q.size() != 0); i++) @(negedge clk);
        check("drain_resp_q", 32'(resp_q.size()), 32'd0);
        check("drain_wr_q", 32'(wr_q.size()), 32'd0);
    endtask

    // Both ports request continuously; port 0 stores, port 1 loads 0x8.
    task automatic fair(input int ntx, input logic [31:0] base);
        int n;
        int k0;
        int k1;
        int last_acc;
        int idle_run;
        int max_idle;
        int g;
        n = 0; k0 = 0; k1 = 0; last_acc = 0; idle_run = 0; max_idle = 0;
        @(posedge clk); #1;
        drive(0, 1'b1, base, 32'hA000_0000);
        drive(1, 1'b0, 32'h8, 32'd0);
        for (int i = 0; i < 60 && n < ntx; i++) begin
            @(negedge clk);
            if (!busy) idle_run++; else idle_run = 0;
            if (idle_run > max_idle) max_idle = idle_run;
            if (req_ready != 2'b00) begin
                g = req_ready[1] ? 1 : 0;
                check("grant_order", 32'(g), 32'(n % 2));
                if (n > 0) check("accept_spacing", 32'(cyc - last_acc), 32'd3);
                last_acc = cyc;
                if (g == 0) begin
                    resp_q.push_back('{0, 1'b0, 32'd0, cyc + 3});
                    wr_q.push_back('{base + 32'(4 * k0), 32'hA000_0000 + 32'(k0), cyc + 2});
                end else begin
                    resp_q.push_back('{1, 1'b0, 32'hDEAD_BEEF, cyc + 3});
                end
                n++;
                @(posedge clk); #1;
                if (g == 0) begin
                    k0++;
                    drive(0, 1'b1, base + 32'(4 * k0), 32'hA000_0000 + 32'(k0));
                end else begin
                    k1++;
                end
            end
        end
        req_valid = 2'b00;
        check("fair_count", 32'(n), 32'(ntx));
        check("busy_gap", 32'(max_idle), 32'd1);
        drain();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        reset = 1'b0;
        req_valid = 2'b00; req_write = 2'b00;
        req_addr0 = 32'd0; req_addr1 = 32'd0;
        req_wdata0 = 32'd0; req_wdata1 = 32'd0;
        req_valid_z = 2'b00; req_addr_z = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        reset = 1'b1;

        single(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
        drain();
        single(1, 1'b0, 32'h8, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        drain();
        fair(4, 32'h20);
        single(0, 1'b1, 32'h6, 32'h0000_0055, 32'd0, 1'b1, 1'b0);
        drain();

        // Zero-wait instance: ACCESS directly after acceptance.
        @(posedge clk); #1;
        req_valid_z = 2'b01; req_addr_z = 32'h4;
        @(negedge clk);
        check("z_ready", 32'(req_ready_z), 32'd1);
        @(posedge clk); #1;
        req_valid_z = 2'b00;
        @(negedge clk);
        check("z_access_busy", 32'(busy_z), 32'd1);
        check("z_access_addr", mem_address_z, 32'h4);
        check("z_access_we", 32'(mem_write_enable_z), 32'd0);
        @(negedge clk);
        check("z_resp_valid", 32'(resp_valid_z), 32'd1);
        check("z_resp_rdata", resp_rdata_z, 32'h1234_5678);
        check("z_resp_err", 32'(resp_err_z), 32'd0);

        // Reset during WAIT of a store: aborted, nothing reaches memory.
        @(posedge clk); #1;
        drive(0, 1'b1, 32'h10, 32'hBAD0_BAD0);
        @(negedge clk);
        check("abort_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b11;
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_addr", mem_address, 32'd0);
        check("abort_din", mem_data_in, 32'd0);
        check("abort_ready_gated", 32'(req_ready), 32'd0);
        check("abort_rdata", resp_rdata, 32'd0);
        repeat (4) @(negedge clk);
        check("abort_no_write", mem[4], 32'd0);
        req_valid = 2'b00;
        reset = 1'b1;
        fair(2, 32'h30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single-port, word-addressed data memory between two requesters: port 0 is the CPU load/store path, port 1 is a loader/debug master.
- Round-robin arbitration, one transaction at a time, with a configurable memory access latency.
- Sits between the requesters and the data memory's address / data_in / write_enable / data_out pins.
- Returns read data and completion as a registered one-cycle response pulse.

Parameters:
- WAIT_CYCLES, 1, extra cycles between acceptance and the memory access cycle; legal range 0..15.

Ports:
- clk  input  1  clock, all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- req_valid  input  2  per-requester request valid, bit i = requester i
- req_write  input  2  per-requester 1 = store, 0 = load
- req_addr0 / req_addr1  input  32 each  byte address
- req_wdata0 / req_wdata1  input  32 each  store data
- req_ready  output  2  one-hot acceptance strobe
- resp_valid  output  2  one-hot completion pulse
- resp_err  output  1  completed transaction was misaligned; valid with resp_valid
- resp_rdata  output  32  load data; valid with resp_valid
- mem_address  output  32  to memory address
- mem_data_in  output  32  to memory data_in
- mem_write_enable  output  1  to memory write_enable
- mem_data_out  input  32  from memory data_out (combinational read)
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, last_grant = 1, so requester 0 wins first.
  - All outputs 0; latched addr/wdata/write/owner cleared; counter 0.
  - A reset asserted mid-transaction aborts it: no write is issued and no response is sent.
- FSM states: IDLE -> WAIT -> ACCESS -> IDLE.
- IDLE:
  - If any req_valid bit is set, grant one requester.
  - Both valid: grant the one not equal to last_grant. One valid: grant it.
  - req_ready[g] = 1 combinationally in that cycle only; acceptance = req_valid[g] & req_ready[g].
  - On acceptance, latch addr, wdata, write, owner = g and set last_grant = g.
  - Next state is WAIT with counter = WAIT_CYCLES, or ACCESS if WAIT_CYCLES = 0.
  - req_ready is 0 in every non-IDLE state.
  - The losing requester must hold valid and payload stable until it is accepted.
- WAIT: counter decrements each cycle; when counter = 1 at the clock edge, next state is ACCESS.
- ACCESS (exactly 1 cycle):
  - Aligned store (addr[1:0] = 0): mem_write_enable = 1 for this cycle only.
  - Aligned load: mem_data_out is captured into the resp_rdata register.
  - Misaligned (addr[1:0] != 0): no write is issued, resp_rdata = 0, resp_err is set.
  - Next state is IDLE.
- Response:
  - resp_valid[owner] pulses for exactly 1 cycle, in the cycle after ACCESS (concurrent with IDLE).
  - resp_err and resp_rdata are valid with that pulse and hold until the next response.
  - resp_rdata = 0 for stores.
- Latency: acceptance at cycle T; ACCESS at T+WAIT_CYCLES+1; resp_valid at T+WAIT_CYCLES+2.
- Back-to-back: a new request can be accepted in the same cycle resp_valid pulses, giving a throughput of 1 transaction per WAIT_CYCLES+2 cycles.
- mem_address and mem_data_in:
  - Driven from the latched values in WAIT and ACCESS; 0 in IDLE.
  - Full 32-bit address passed through; the memory drops bits [1:0].
- Fairness: under continuous requests on both ports, grants strictly alternate.

Optional Feature:
- Macro: ARB_PERF_COUNTERS_EN.
- Defined: adds outputs grant_count0 and grant_count1 (32 bit each) and conflict_count (32 bit).
  - grant_countN increments on each acceptance for requester N.
  - conflict_count increments on each IDLE cycle with both req_valid bits set while an acceptance occurs.
  - All counters wrap at 2^32 and clear on reset.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- WAIT_CYCLES=1, reset released, req_valid=01 store addr 0x8 wdata 0xDEADBEEF:
  - req_ready=01 at T; mem_write_enable=1 with mem_address=0x8 at T+2.
  - resp_valid=01 at T+3; resp_err=0.
- Then req_valid=10 load addr 0x8 with mem_data_out=0xDEADBEEF at ACCESS -> resp_valid=10, resp_rdata=0xDEADBEEF, 3 cycles after acceptance.
- Both ports valid continuously, 4 transactions -> grant order 0,1,0,1; each acceptance on the resp_valid cycle of the previous one; busy never low for more than that cycle.
- Store addr 0x6 -> mem_write_enable stays 0; resp_err=1; resp_rdata=0.
- WAIT_CYCLES=0 load -> ACCESS at T+1, resp_valid at T+2.
- reset driven low during WAIT of a store -> outputs 0 immediately and asynchronously; no write and no resp_valid ever appear; after release, requester 0 wins a simultaneous request.
